load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 239 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: bridges one core memory request to a single-beat
// data-memory handshake, with lane steering, load formatting and timeout.
// Ports:
//   CLK, RST_N             clock, async active-low reset
//   REQ_VALID/READY        core request handshake (READY only in IDLE)
//   REQ_WE/FUNCT3/ADDR/WDATA  request fields, latched on acceptance
//   MEM_REQ/WE/ADDR/WSTRB/WDATA  registered memory request, held to ACK
//   MEM_ACK/RDATA          memory completion and read word
//   LOAD_DATA              formatted load result, held between loads
//   DONE / ERR             one-cycle completion / reject-or-timeout pulses
//   BUSY                   stall request, high whenever not IDLE
module load_store_unit #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [2:0]  REQ_FUNCT3,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  MEM_WSTRB,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic [31:0] LOAD_DATA,
  output logic        DONE,
  output logic        ERR,
  output logic        BUSY
);

  localparam int CW =
    (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam bit TO_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  alo_q, alo_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        f3_ok;
  logic        align_ok;
  logic        legal;
  logic [3:0]  strb_c;
  logic [31:0] wdat_c;
  logic [31:0] fmt_c;
  logic        to_hit;

  // Request legality: funct3 set differs for loads and stores.
  always_comb begin
    f3_ok = 1'b0;
    unique case (1'b1)
      REQ_WE:  f3_ok = (REQ_FUNCT3 <= 3'b010);
      default: f3_ok = (REQ_FUNCT3 != 3'b011) &&
                       (REQ_FUNCT3 != 3'b110) &&
                       (REQ_FUNCT3 != 3'b111);
    endcase
  end

  always_comb begin
    align_ok = 1'b1;
    unique case (REQ_FUNCT3[1:0])
      2'b01:   align_ok = ~REQ_ADDR[0];
      2'b10:   align_ok = (REQ_ADDR[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
  end

  assign legal = f3_ok & align_ok;

  // Store lane steering; loads never write.
  always_comb begin
    strb_c = 4'b1111;
    wdat_c = REQ_WDATA;
    unique case (REQ_FUNCT3[1:0])
      2'b00: begin
        strb_c = 4'b0001 << REQ_ADDR[1:0];
        wdat_c = {4{REQ_WDATA[7:0]}};
      end
      2'b01: begin
        strb_c = REQ_ADDR[1] ? 4'b1100 : 4'b0011;
        wdat_c = {2{REQ_WDATA[15:0]}};
      end
      default: begin
        strb_c = 4'b1111;
        wdat_c = REQ_WDATA;
      end
    endcase
    if (!REQ_WE) strb_c = 4'b0000;
  end

  // Load formatting from the latched funct3 and address low bits.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    logic        sx;
    sx = ~f3_q[2];
    unique case (alo_q)
      2'b00:   b = MEM_RDATA[7:0];
      2'b01:   b = MEM_RDATA[15:8];
      2'b10:   b = MEM_RDATA[23:16];
      default: b = MEM_RDATA[31:24];
    endcase
    h = alo_q[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
    unique case (f3_q[1:0])
      2'b00:   fmt_c = {{24{sx & b[7]}}, b};
      2'b01:   fmt_c = {{16{sx & h[15]}}, h};
      default: fmt_c = MEM_RDATA;
    endcase
  end

  assign to_hit = TO_EN && (cnt_q == TO_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      alo_q       <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      load_data_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      alo_q       <= alo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      load_data_q <= load_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic. ACK takes priority over timeout on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:
        if (REQ_VALID && legal) state_d = ACCESS;
      ACCESS:
        if (MEM_ACK)     state_d = RESP;
        else if (to_hit) state_d = IDLE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered output / datapath updates.
  always_comb begin
    we_d        = we_q;
    f3_d        = f3_q;
    alo_d       = alo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    load_data_d = load_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          we_d  = REQ_WE;
          f3_d  = REQ_FUNCT3;
          alo_d = REQ_ADDR[1:0];
          if (legal) begin
            mem_req_d   = 1'b1;
            mem_we_d    = REQ_WE;
            mem_addr_d  = {REQ_ADDR[31:2], 2'b00};
            mem_wstrb_d = strb_c;
            mem_wdata_d = wdat_c;
            cnt_d       = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (MEM_ACK) begin
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          if (!we_q) load_data_d = fmt_c;
        end else if (to_hit) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign REQ_READY = (state_q == IDLE);
  assign BUSY      = (state_q != IDLE);
  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WSTRB = mem_wstrb_q;
  assign MEM_WDATA = mem_wdata_q;
  assign LOAD_DATA = load_data_q;
  assign DONE      = done_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a queue of expected responses.
// DUT built with TIMEOUT_CYC=4 so the timeout path is reachable quickly.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [2:0]  REQ_FUNCT3;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [3:0]  MEM_WSTRB;
  logic [31:0] MEM_WDATA;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;
  logic [31:0] LOAD_DATA;
  logic        DONE;
  logic        ERR;
  logic        BUSY;

  load_store_unit #(.TIMEOUT_CYC(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_WE(REQ_WE), .REQ_FUNCT3(REQ_FUNCT3),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WSTRB(MEM_WSTRB),
    .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK),
    .MEM_RDATA(MEM_RDATA), .LOAD_DATA(LOAD_DATA),
    .DONE(DONE), .ERR(ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] ld;
    logic        err;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic [31:0] addr,
                              input logic [3:0] strb,
                              input logic [31:0] wdata,
                              input logic [31:0] ld, input logic err);
    exp_t e;
    e.we = we; e.addr = addr; e.strb = strb;
    e.wdata = wdata; e.ld = ld; e.err = err;
    return e;
  endfunction

  task automatic access(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int dly);
    exp_t e;
    REQ_VALID = 1'b1; REQ_WE = we; REQ_FUNCT3 = f3;
    REQ_ADDR = addr; REQ_WDATA = wdata; MEM_RDATA = rdata;
    chk("req_ready_idle", 32'(REQ_READY), 32'd1);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    if (sbq.size() == 0) begin
      n_vec++; n_bad++;
      $error("FAIL scoreboard_empty: got 0 want 1");
      return;
    end
    e = sbq.pop_front();
    if (e.err) begin
      chk("err_pulse", 32'(ERR), 32'd1);
      chk("err_no_memreq", 32'(MEM_REQ), 32'd0);
      chk("err_ready", 32'(REQ_READY), 32'd1);
      chk("err_no_done", 32'(DONE), 32'd0);
      chk("err_ld_keep", LOAD_DATA, e.ld);
      @(posedge CLK); #1;
      chk("err_pulse_end", 32'(ERR), 32'd0);
      chk("err_no_memreq2", 32'(MEM_REQ), 32'd0);
      return;
    end
    chk("mem_req", 32'(MEM_REQ), 32'd1);
    chk("mem_addr", MEM_ADDR, e.addr);
    chk("mem_we", 32'(MEM_WE), 32'(e.we));
    chk("mem_wstrb", 32'(MEM_WSTRB), 32'(e.strb));
    if (e.we) chk("mem_wdata", MEM_WDATA, e.wdata);
    chk("busy", 32'(BUSY), 32'd1);
    chk("ready_low", 32'(REQ_READY), 32'd0);
    for (int i = 0; i < dly; i++) begin
      @(posedge CLK); #1;
      chk("mem_req_hold", 32'(MEM_REQ), 32'd1);
      chk("mem_addr_hold", MEM_ADDR, e.addr);
      chk("mem_wstrb_hold", 32'(MEM_WSTRB), 32'(e.strb));
      chk("no_early_done", 32'(DONE), 32'd0);
    end
    MEM_ACK = 1'b1;
    @(posedge CLK); #1;
    MEM_ACK = 1'b0;
    chk("done", 32'(DONE), 32'd1);
    chk("no_err_with_done", 32'(ERR), 32'd0);
    chk("mem_req_drop", 32'(MEM_REQ), 32'd0);
    chk("load_data", LOAD_DATA, e.ld);
    chk("busy_resp", 32'(BUSY), 32'd1);
    @(posedge CLK); #1;
    chk("done_end", 32'(DONE), 32'd0);
    chk("ready_back", 32'(REQ_READY), 32'd1);
    chk("busy_end", 32'(BUSY), 32'd0);
    chk("load_hold", LOAD_DATA, e.ld);
  endtask

  initial begin
    RST_N = 1'b0; REQ_VALID = 1'b0; REQ_WE = 1'b0;
    REQ_FUNCT3 = 3'b000; REQ_ADDR = '0; REQ_WDATA = '0;
    MEM_ACK = 1'b0; MEM_RDATA = '0;
    #12;
    chk("rst_ready", 32'(REQ_READY), 32'd1);
    chk("rst_memreq", 32'(MEM_REQ), 32'd0);
    chk("rst_memwe", 32'(MEM_WE), 32'd0);
    chk("rst_memaddr", MEM_ADDR, 32'd0);
    chk("rst_wstrb", 32'(MEM_WSTRB), 32'd0);
    chk("rst_wdata", MEM_WDATA, 32'd0);
    chk("rst_ld", LOAD_DATA, 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;

    // LB, byte lane 3, negative
    sbq.push_back(mk(0, 32'h1000, 4'h0, 0, 32'hFFFF_FF80, 0));
    access(0, 3'b000, 32'h0000_1003, 0, 32'h80FF_0000, 2);
    // LHU / LH upper half
    sbq.push_back(mk(0, 32'h0, 4'h0, 0, 32'h0000_BEEF, 0));
    access(0, 3'b101, 32'h0000_0002, 0, 32'hBEEF_1234, 1);
    sbq.push_back(mk(0, 32'h0, 4'h0, 0, 32'hFFFF_BEEF, 0));
    access(0, 3'b001, 32'h0000_0002, 0, 32'hBEEF_1234, 0);
    // SB lane 1
    sbq.push_back(mk(1, 32'h10, 4'b0010, 32'hABAB_ABAB,
                     32'hFFFF_BEEF, 0));
    access(1, 3'b000, 32'h0000_0011, 32'h1234_56AB, 32'hFFFF_FFFF, 1);
    // SH upper half
    sbq.push_back(mk(1, 32'h4, 4'b1100, 32'hCAFE_CAFE,
                     32'hFFFF_BEEF, 0));
    access(1, 3'b001, 32'h0000_0006, 32'h5555_CAFE, 0, 0);
    // SW, ACK on the would-be timeout edge completes normally
    sbq.push_back(mk(1, 32'h8, 4'b1111, 32'hDEAD_BEEF,
                     32'hFFFF_BEEF, 0));
    access(1, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 0, 3);
    // LBU lane 1 zero-extends
    sbq.push_back(mk(0, 32'h0, 4'h0, 0, 32'h0000_0080, 0));
    access(0, 3'b100, 32'h0000_0001, 0, 32'h1234_8056, 1);
    // LW, immediate ACK
    sbq.push_back(mk(0, 32'hC, 4'h0, 0, 32'h89AB_CDEF, 0));
    access(0, 3'b010, 32'h0000_000C, 0, 32'h89AB_CDEF, 0);
    // LH lower half negative
    sbq.push_back(mk(0, 32'h0, 4'h0, 0, 32'hFFFF_8001, 0));
    access(0, 3'b001, 32'h0000_0000, 0, 32'h7777_8001, 1);

    // Rejected requests
    sbq.push_back(mk(0, 0, 0, 0, 32'hFFFF_8001, 1));
    access(1, 3'b010, 32'h0000_0006, 32'h1, 0, 0);
    sbq.push_back(mk(0, 0, 0, 0, 32'hFFFF_8001, 1));
    access(0, 3'b011, 32'h0000_0000, 0, 0, 0);
    sbq.push_back(mk(0, 0, 0, 0, 32'hFFFF_8001, 1));
    access(0, 3'b001, 32'h0000_0001, 0, 0, 0);
    sbq.push_back(mk(0, 0, 0, 0, 32'hFFFF_8001, 1));
    access(0, 3'b010, 32'h0000_0002, 0, 0, 0);
    sbq.push_back(mk(0, 0, 0, 0, 32'hFFFF_8001, 1));
    access(1, 3'b100, 32'h0000_0000, 0, 0, 0);
    sbq.push_back(mk(0, 0, 0, 0, 32'hFFFF_8001, 1));
    access(0, 3'b110, 32'h0000_0000, 0, 0, 0);

    // Timeout: no ACK for a LW
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_FUNCT3 = 3'b010;
    REQ_ADDR = 32'h20;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_memreq_high", 32'(MEM_REQ), 32'd1);
      chk("to_no_err_yet", 32'(ERR), 32'd0);
      @(posedge CLK); #1;
    end
    chk("to_memreq_drop", 32'(MEM_REQ), 32'd0);
    chk("to_err", 32'(ERR), 32'd1);
    chk("to_no_done", 32'(DONE), 32'd0);
    chk("to_ready", 32'(REQ_READY), 32'd1);
    @(posedge CLK); #1;
    MEM_ACK = 1'b1; MEM_RDATA = 32'hFFFF_FFFF;
    @(posedge CLK); #1;
    MEM_ACK = 1'b0;
    chk("late_ack_done", 32'(DONE), 32'd0);
    chk("late_ack_err", 32'(ERR), 32'd0);
    chk("late_ack_ld", LOAD_DATA, 32'hFFFF_8001);
    chk("late_ack_ready", 32'(REQ_READY), 32'd1);

    // Reset in the middle of an access
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_FUNCT3 = 3'b010;
    REQ_ADDR = 32'h40;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    chk("ra_memreq", 32'(MEM_REQ), 32'd1);
    @(posedge CLK); #1;
    RST_N = 1'b0;
    #1;
    chk("ra_memreq_zero", 32'(MEM_REQ), 32'd0);
    chk("ra_memaddr_zero", MEM_ADDR, 32'd0);
    chk("ra_no_done", 32'(DONE), 32'd0);
    chk("ra_ld_zero", LOAD_DATA, 32'd0);
    chk("ra_busy", 32'(BUSY), 32'd0);
    chk("ra_ready", 32'(REQ_READY), 32'd1);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    MEM_ACK = 1'b1; MEM_RDATA = 32'hDEAD_DEAD;
    @(posedge CLK); #1;
    MEM_ACK = 1'b0;
    chk("ra_late_done", 32'(DONE), 32'd0);
    chk("ra_late_err", 32'(ERR), 32'd0);
    chk("ra_late_ld", LOAD_DATA, 32'd0);
    chk("ra_late_memreq", 32'(MEM_REQ), 32'd0);
    sbq.push_back(mk(0, 32'h44, 4'h0, 0, 32'h1122_3344, 0));
    access(0, 3'b010, 32'h0000_0044, 0, 32'h1122_3344, 1);

    n_vec++;
    assert (sbq.size() == 0) else begin
      n_bad++;
      $error("FAIL sb_drain: got %0d want 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
